// File: rtl/chip_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : chip_bank_scheduler
// Description : Single-outstanding burst scheduler driving one DRAM chip's
//               per-bank row/column/strobe buses with open-row tracking.
// Revision    : 1.0
// ============================================================================
module chip_bank_scheduler #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int T_RP         = 3,
    parameter int T_RCD        = 3,
    parameter int RD_LAT       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [BGWIDTH-1:0]            req_bg,
    input  logic [BAWIDTH-1:0]            req_ba,
    input  logic [ADDRWIDTH-1:0]          req_row,
    input  logic [COLWIDTH-1:0]           req_col,
    input  logic [BL*DEVICE_WIDTH-1:0]    req_wdata,
    output logic                          rsp_valid,
    output logic [DEVICE_WIDTH-1:0]       rsp_data,
    output logic                          rsp_last,
    output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0]                   rd_o_wr,
    output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0] dqin,
    input  logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][DEVICE_WIDTH-1:0] dqout,
    output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][ADDRWIDTH-1:0]    row,
    output logic [2**BGWIDTH-1:0][2**BAWIDTH-1:0][COLWIDTH-1:0]     column
);

    localparam int BANKGROUPS    = 2**BGWIDTH;
    localparam int BANKSPERGROUP = 2**BAWIDTH;
    localparam int BANKIDX       = BGWIDTH + BAWIDTH;
    localparam int NBANKS        = 2**BANKIDX;
    localparam int MAX_A         = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int MAX_B         = (RD_LAT > BL) ? RD_LAT : BL;
    localparam int MAXC          = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW            = $clog2(MAXC + 1);

    localparam logic [CW-1:0] C_RP_LOAD   = CW'(T_RP - 1);
    localparam logic [CW-1:0] C_RCD_LOAD  = CW'(T_RCD - 1);
    localparam logic [CW-1:0] C_LAT_LOAD  = CW'(RD_LAT - 1);
    localparam logic [CW-1:0] C_BEAT_LAST = CW'(BL - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_ACT    = 3'd2,
        S_ACCESS = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic                       wr_q, wr_d;
    logic [BGWIDTH-1:0]         bg_q, bg_d;
    logic [BAWIDTH-1:0]         ba_q, ba_d;
    logic [ADDRWIDTH-1:0]       req_row_q, req_row_d;
    logic [COLWIDTH-1:0]        req_col_q, req_col_d;
    logic [BL*DEVICE_WIDTH-1:0] wdata_q, wdata_d;

    logic [NBANKS-1:0]                open_q, open_d;
    logic [NBANKS-1:0][ADDRWIDTH-1:0] open_row_q, open_row_d;

    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                   rd_o_wr_q, rd_o_wr_d;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][DEVICE_WIDTH-1:0] dqin_q, dqin_d;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0]    row_q, row_d;
    logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][COLWIDTH-1:0]     column_q, column_d;

    logic [RD_LAT:0]           pipe_v_q, pipe_v_d;
    logic [RD_LAT:0]           pipe_l_q, pipe_l_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_last_q, rsp_last_d;
    logic [DEVICE_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic [BANKIDX-1:0] w_in_idx;
    logic [BANKIDX-1:0] w_cur_idx;
    logic               w_issue_rd;
    logic               w_issue_last;
    logic               w_wr_done;

    assign w_in_idx  = {req_bg, req_ba};
    assign w_cur_idx = {bg_q, ba_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        bg_d         = bg_q;
        ba_d         = ba_q;
        req_row_d    = req_row_q;
        req_col_d    = req_col_q;
        wdata_d      = wdata_q;
        open_d       = open_q;
        open_row_d   = open_row_q;
        row_d        = row_q;
        column_d     = column_q;
        rd_o_wr_d    = '0;
        dqin_d       = '0;
        w_issue_rd   = 1'b0;
        w_issue_last = 1'b0;
        w_wr_done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d      = req_wr;
                    bg_d      = req_bg;
                    ba_d      = req_ba;
                    req_row_d = req_row;
                    req_col_d = req_col;
                    wdata_d   = req_wdata;
                    if (open_q[w_in_idx] && (open_row_q[w_in_idx] == req_row)) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                    end else if (open_q[w_in_idx]) begin
                        open_d[w_in_idx] = 1'b0;
                        state_d          = S_PRE;
                        cnt_d            = C_RP_LOAD;
                    end else begin
                        state_d               = S_ACT;
                        cnt_d                 = C_RCD_LOAD;
                        row_d[req_bg][req_ba] = req_row;
                    end
                end
            end
            S_PRE: begin
                if (cnt_q == '0) begin
                    state_d           = S_ACT;
                    cnt_d             = C_RCD_LOAD;
                    row_d[bg_q][ba_q] = req_row_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACT: begin
                if (cnt_q == '0) begin
                    open_d[w_cur_idx]     = 1'b1;
                    open_row_d[w_cur_idx] = req_row_q;
                    state_d               = S_ACCESS;
                    cnt_d                 = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACCESS: begin
                // Bank-side buses are registered here, so each beat appears one cycle after its ACCESS cycle.
                rd_o_wr_d[bg_q][ba_q] = wr_q;
                dqin_d[bg_q][ba_q]    = wr_q ? wdata_q[DEVICE_WIDTH-1:0] : '0;
                column_d[bg_q][ba_q]  = req_col_q + COLWIDTH'(cnt_q);
                wdata_d               = wdata_q >> DEVICE_WIDTH;
                w_issue_rd            = ~wr_q;
                w_issue_last          = ~wr_q && (cnt_q == C_BEAT_LAST);
                if (cnt_q == C_BEAT_LAST) begin
                    if (wr_q) begin
                        state_d   = S_IDLE;
                        w_wr_done = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = C_LAT_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stage 0 marks the beat's issue edge; stage RD_LAT is when dqout for that beat is valid.
        pipe_v_d    = {pipe_v_q[RD_LAT-1:0], w_issue_rd};
        pipe_l_d    = {pipe_l_q[RD_LAT-1:0], w_issue_last};
        rsp_valid_d = pipe_v_q[RD_LAT];
        rsp_data_d  = pipe_v_q[RD_LAT] ? dqout[bg_q][ba_q] : '0;
        rsp_last_d  = w_wr_done | (pipe_v_q[RD_LAT] & pipe_l_q[RD_LAT]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            bg_q        <= '0;
            ba_q        <= '0;
            req_row_q   <= '0;
            req_col_q   <= '0;
            wdata_q     <= '0;
            open_q      <= '0;
            open_row_q  <= '0;
            rd_o_wr_q   <= '0;
            dqin_q      <= '0;
            row_q       <= '0;
            column_q    <= '0;
            pipe_v_q    <= '0;
            pipe_l_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            bg_q        <= bg_d;
            ba_q        <= ba_d;
            req_row_q   <= req_row_d;
            req_col_q   <= req_col_d;
            wdata_q     <= wdata_d;
            open_q      <= open_d;
            open_row_q  <= open_row_d;
            rd_o_wr_q   <= rd_o_wr_d;
            dqin_q      <= dqin_d;
            row_q       <= row_d;
            column_q    <= column_d;
            pipe_v_q    <= pipe_v_d;
            pipe_l_q    <= pipe_l_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
    assign rd_o_wr   = rd_o_wr_q;
    assign dqin      = dqin_q;
    assign row       = row_q;
    assign column    = column_q;

endmodule
`default_nettype wire

// File: tb/tb_chip_bank_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip_bank_scheduler
// Description : Directed bench for chip_bank_scheduler with a small chip model.
// Revision    : 1.0
// ============================================================================
module tb_chip_bank_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid, req_ready, req_wr;
    logic [1:0]  req_bg, req_ba;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_last;
    logic [3:0]  rsp_data;
    logic [3:0][3:0]        rd_o_wr;
    logic [3:0][3:0][3:0]   dqin, dqout;
    logic [3:0][3:0][16:0]  row;
    logic [3:0][3:0][9:0]   column;

    int n_checks = 0;
    int n_fail   = 0;

    chip_bank_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rd_o_wr(rd_o_wr), .dqin(dqin), .dqout(dqout), .row(row), .column(column)
    );

    always #5 clk = ~clk;

    // Chip model: per-bank storage keyed by row/column, read data returned RD_LAT (=2) cycles later.
    typedef logic [3:0][3:0][3:0] dq_t;
    dq_t        stg1 = '0;
    dq_t        stg2 = '0;
    dq_t        mdl_nxt;
    bit [31:0]  mdl_key;
    logic [3:0] mem [bit [31:0]];
    assign dqout = stg2;

    function automatic bit [31:0] mkey(input int g, input int a, input logic [16:0] r, input logic [9:0] c);
        logic [1:0] gg, aa;
        gg = g[1:0];
        aa = a[1:0];
        return {1'b0, gg, aa, r, c};
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w >> (4 * i);
        return t[3:0];
    endfunction

    always @(posedge clk) begin
        for (int g = 0; g < 4; g++) begin
            for (int a = 0; a < 4; a++) begin
                mdl_key = mkey(g, a, row[g][a], column[g][a]);
                mdl_nxt[g][a] = mem.exists(mdl_key) ? mem[mdl_key] : 4'h0;
            end
        end
        stg2 <= stg1;
        stg1 <= mdl_nxt;
        for (int g = 0; g < 4; g++) begin
            for (int a = 0; a < 4; a++) begin
                if (rd_o_wr[g][a]) mem[mkey(g, a, row[g][a], column[g][a])] = dqin[g][a];
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_req(input logic wr, input logic [1:0] bg, input logic [1:0] ba,
                            input logic [16:0] r, input logic [9:0] c, input logic [31:0] wd);
        int t;
        t = 0;
        req_wr = wr; req_bg = bg; req_ba = ba; req_row = r; req_col = c; req_wdata = wd;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout got req_ready=%b exp=1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_data !== 4'h0) begin
            n_fail++; $display("FAIL reset_rsp got v=%b l=%b d=%h exp 0/0/0", rsp_valid, rsp_last, rsp_data); end
        n_checks++; if (rd_o_wr !== '0 || dqin !== '0) begin
            n_fail++; $display("FAIL reset_strobe got=%h dqin=%h exp 0", rd_o_wr, dqin); end
        n_checks++; if (row !== '0 || column !== '0) begin
            n_fail++; $display("FAIL reset_addr got row=%h col=%h exp 0", row, column); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_closed_write();
        logic [9:0] ec;
        int b;
        send_req(1'b1, 2'd1, 2'd2, 17'h000A5, 10'h3F8, 32'h87654321);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            b = k - 4;
            ec = 10'h3F8 + 10'(b);
            n_checks++; if (rd_o_wr !== ((k >= 4 && k <= 11) ? 16'h0040 : 16'h0000)) begin
                n_fail++; $display("FAIL cw_strobe k=%0d got=%h", k, rd_o_wr); end
            if (k >= 4 && k <= 11) begin
                n_checks++; if (column[1][2] !== ec) begin n_fail++; $display("FAIL cw_column k=%0d got=%h exp=%h", k, column[1][2], ec); end
                n_checks++; if (dqin[1][2] !== 4'(b + 1)) begin n_fail++; $display("FAIL cw_dqin k=%0d got=%h exp=%h", k, dqin[1][2], 4'(b + 1)); end
            end
            n_checks++; if (rsp_last !== (k == 11) || rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL cw_rsp k=%0d got last=%b valid=%b exp last=%b valid=0", k, rsp_last, rsp_valid, (k == 11)); end
            n_checks++; if (row[1][2] !== 17'h000A5) begin n_fail++; $display("FAIL cw_row k=%0d got=%h exp=000a5", k, row[1][2]); end
            n_checks++; if (req_ready !== (k >= 11)) begin n_fail++; $display("FAIL cw_ready k=%0d got=%b exp=%b", k, req_ready, (k >= 11)); end
        end
    endtask

    task automatic test_hit_read();
        logic [9:0] ec;
        send_req(1'b0, 2'd1, 2'd2, 17'h000A5, 10'h3F8, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            ec = 10'h3F8 + 10'(k - 1);
            if (k <= 8) begin
                n_checks++; if (column[1][2] !== ec) begin n_fail++; $display("FAIL hr_column k=%0d got=%h exp=%h", k, column[1][2], ec); end
            end
            n_checks++; if (rd_o_wr !== 16'h0) begin n_fail++; $display("FAIL hr_strobe k=%0d got=%h exp=0", k, rd_o_wr); end
            n_checks++; if (rsp_valid !== (k >= 4 && k <= 11) || rsp_last !== (k == 11)) begin
                n_fail++; $display("FAIL hr_rsp k=%0d got v=%b l=%b", k, rsp_valid, rsp_last); end
            if (k >= 4 && k <= 11) begin
                n_checks++; if (rsp_data !== 4'(k - 3)) begin n_fail++; $display("FAIL hr_data k=%0d got=%h exp=%h", k, rsp_data, 4'(k - 3)); end
            end
            n_checks++; if (req_ready !== (k >= 10)) begin n_fail++; $display("FAIL hr_ready k=%0d got=%b exp=%b", k, req_ready, (k >= 10)); end
        end
    endtask

    task automatic test_miss_read();
        logic [9:0] ec;
        logic [16:0] er;
        send_req(1'b0, 2'd1, 2'd2, 17'h000A6, 10'h3F8, 32'h0);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            er = (k >= 3) ? 17'h000A6 : 17'h000A5;
            ec = (k <= 6) ? 10'h3FF : ((k <= 14) ? 10'h3F8 + 10'(k - 7) : 10'h3FF);
            n_checks++; if (row[1][2] !== er) begin n_fail++; $display("FAIL mr_row k=%0d got=%h exp=%h", k, row[1][2], er); end
            n_checks++; if (column[1][2] !== ec) begin n_fail++; $display("FAIL mr_column k=%0d got=%h exp=%h", k, column[1][2], ec); end
            n_checks++; if (rsp_valid !== (k >= 10 && k <= 17) || rsp_last !== (k == 17) || rsp_data !== 4'h0) begin
                n_fail++; $display("FAIL mr_rsp k=%0d got v=%b l=%b d=%h", k, rsp_valid, rsp_last, rsp_data); end
            n_checks++; if (req_ready !== (k >= 16)) begin n_fail++; $display("FAIL mr_ready k=%0d got=%b exp=%b", k, req_ready, (k >= 16)); end
        end
    endtask

    task automatic test_column_wrap();
        logic [9:0] ec;
        logic [9:0] wrap_seq [8];
        wrap_seq = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
        send_req(1'b1, 2'd1, 2'd2, 17'h000A6, 10'h3FE, 32'hFEDCBA98);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ec = wrap_seq[k - 1];
            n_checks++; if (column[1][2] !== ec) begin n_fail++; $display("FAIL wrap_column k=%0d got=%h exp=%h", k, column[1][2], ec); end
            n_checks++; if (rd_o_wr !== 16'h0040 || dqin[1][2] !== 4'(k + 7)) begin
                n_fail++; $display("FAIL wrap_wbeat k=%0d got strobe=%h d=%h exp 0040/%h", k, rd_o_wr, dqin[1][2], 4'(k + 7)); end
            n_checks++; if (rsp_last !== (k == 8)) begin n_fail++; $display("FAIL wrap_last k=%0d got=%b", k, rsp_last); end
        end
        // Back-to-back: accept on the first edge after the write burst.
        send_req(1'b0, 2'd1, 2'd2, 17'h000A6, 10'h3FE, 32'h0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 8) begin
                n_checks++; if (column[1][2] !== wrap_seq[k - 1]) begin n_fail++; $display("FAIL wrap_rcol k=%0d got=%h exp=%h", k, column[1][2], wrap_seq[k - 1]); end
            end
            if (k >= 4 && k <= 11) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 4'(k + 4)) begin
                    n_fail++; $display("FAIL wrap_rdata k=%0d got v=%b d=%h exp 1/%h", k, rsp_valid, rsp_data, 4'(k + 4)); end
            end
        end
    endtask

    task automatic test_independent_banks();
        int sel;
        logic [1:0] bg, obg;
        logic [16:0] orow;
        logic [9:0] col;
        logic [31:0] wd;
        send_req(1'b1, 2'd0, 2'd0, 17'h01234, 10'h010, 32'h76543210);
        repeat (12) @(negedge clk);
        send_req(1'b1, 2'd3, 2'd3, 17'h1FFFF, 10'h020, 32'hAAAA5555);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel  = i % 2;
            bg   = (sel == 1) ? 2'd3 : 2'd0;
            obg  = (sel == 1) ? 2'd0 : 2'd3;
            orow = (sel == 1) ? 17'h01234 : 17'h1FFFF;
            col  = (sel == 1) ? 10'h020 : 10'h010;
            wd   = (sel == 1) ? 32'hAAAA5555 : 32'h76543210;
            send_req(1'b0, bg, bg, (sel == 1) ? 17'h1FFFF : 17'h01234, col, 32'h0);
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    n_checks++; if (column[bg][bg] !== col) begin n_fail++; $display("FAIL ib_hit_lat i=%0d got=%h exp=%h", i, column[bg][bg], col); end
                end
                n_checks++; if (row[obg][obg] !== orow) begin n_fail++; $display("FAIL ib_other_row i=%0d k=%0d got=%h exp=%h", i, k, row[obg][obg], orow); end
                if (k >= 4 && k <= 11) begin
                    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== nib(wd, k - 4)) begin
                        n_fail++; $display("FAIL ib_data i=%0d k=%0d got v=%b d=%h exp 1/%h", i, k, rsp_valid, rsp_data, nib(wd, k - 4)); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [9:0] ec;
        send_req(1'b1, 2'd2, 2'd1, 17'h00055, 10'h100, 32'h0000CAFE);
        repeat (7) @(negedge clk);
        n_checks++; if (rd_o_wr !== 16'h0200 || dqin[2][1] !== 4'hC) begin
            n_fail++; $display("FAIL rst_beat3 got strobe=%h d=%h exp 0200/c", rd_o_wr, dqin[2][1]); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rd_o_wr !== '0 || dqin !== '0 || row !== '0 || column !== '0) begin
            n_fail++; $display("FAIL rst_async_bank got strobe=%h row=%h exp 0", rd_o_wr, row); end
        n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_last !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_ctl got rdy=%b v=%b l=%b exp 1/0/0", req_ready, rsp_valid, rsp_last); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (rsp_last !== 1'b0 || rd_o_wr !== '0) begin n_fail++; $display("FAIL rst_hold k=%0d got l=%b strobe=%h", k, rsp_last, rd_o_wr); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_req(1'b0, 2'd2, 2'd1, 17'h00055, 10'h100, 32'h0);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            ec = (k < 4) ? 10'h000 : ((k <= 11) ? 10'h100 + 10'(k - 4) : 10'h107);
            n_checks++; if (column[2][1] !== ec || row[2][1] !== 17'h00055) begin
                n_fail++; $display("FAIL rst_closed_path k=%0d got col=%h row=%h exp %h/00055", k, column[2][1], row[2][1], ec); end
            if (k >= 7) begin
                n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== nib(32'h00000AFE, k - 7) || rsp_last !== (k == 14)) begin
                    n_fail++; $display("FAIL rst_partial k=%0d got v=%b d=%h l=%b exp 1/%h", k, rsp_valid, rsp_data, rsp_last, nib(32'h00000AFE, k - 7)); end
            end
            n_checks++; if (req_ready !== (k >= 13)) begin n_fail++; $display("FAIL rst_ready k=%0d got=%b exp=%b", k, req_ready, (k >= 13)); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0; req_wdata = '0;
        test_reset();
        test_closed_write();
        test_hit_read();
        test_miss_read();
        test_column_wrap();
        test_independent_banks();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
